// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps the fetch unit's PC through request, response and issue to decode,
// applying execute redirects (with squash of the in-flight fetch) and stopping on halt.
module fetch_sequencer #(
    parameter int ADDRESS_BITS = 16,
    parameter int INSTR_BITS   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] PC,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_rvalid,
    input  logic [INSTR_BITS-1:0]   imem_rdata,
    output logic                    instr_valid,
    output logic [INSTR_BITS-1:0]   instr_out,
    output logic [ADDRESS_BITS-1:0] instr_pc,
    input  logic                    decode_stall,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_PC,
    input  logic                    halt,
    output logic [2:0]              fsm_state
);

    // Handshakes: a memory request is accepted on a cycle with imem_req && imem_ready, and its
    // single response arrives on a later cycle with imem_rvalid; an instruction is consumed on a
    // cycle with instr_valid && !decode_stall, and while stalled instr_* hold unchanged.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        DRAIN  = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t state, next_state;
    logic   load_instr;

    assign imem_req  = (state == REQ);
    assign imem_addr = PC;
    assign fsm_state = state;

    // The PC holds by reloading itself; only the WAIT->ISSUE edge selects the increment.
    always_comb begin
        next_state     = state;
        next_PC_select = 1'b1;
        target_PC      = PC;
        load_instr     = 1'b0;
        case (state)
            IDLE: next_state = halt ? HALTED : REQ;
            REQ: begin
                if (redirect) begin
                    target_PC  = redirect_PC;
                    next_state = REQ;
                end else if (imem_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    target_PC  = redirect_PC;
                    // Without the response this cycle it is still owed and must be drained.
                    next_state = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    next_PC_select = 1'b0;
                    load_instr     = 1'b1;
                    next_state     = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    target_PC  = redirect_PC;
                    next_state = halt ? HALTED : REQ;
                end else if (!decode_stall) begin
                    next_state = halt ? HALTED : REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    target_PC  = redirect_PC;
                    next_state = REQ;
                end else if (imem_rvalid) begin
                    next_state = REQ;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= next_state;
            instr_valid <= (next_state == ISSUE);
            if (load_instr) begin
                instr_out <= imem_rdata;
                instr_pc  <= PC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a PC register stands in for the fetch unit, and memory and
// decode are driven cycle by cycle from a vector table plus hand-written halt/reset sequences.
module tb_fetch_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3, S_DRAIN = 3'd4, S_HALTED = 3'd5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        decode_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_PC = 16'h0;
    logic        halt = 1'b0;
    logic [2:0]  fsm_state;

    int compared = 0;
    int failed   = 0;
    logic [47:0] exp_q[$];

    // clock / reset
    always #5 clock = ~clock;

    // fetch-unit model
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= 16'h0;
        else        pc <= next_PC_select ? target_PC : pc + 16'd4;
    end

    fetch_sequencer #(.ADDRESS_BITS(16), .INSTR_BITS(32)) dut (
        .clock(clock), .reset(reset), .PC(pc),
        .next_PC_select(next_PC_select), .target_PC(target_PC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .decode_stall(decode_stall), .redirect(redirect), .redirect_PC(redirect_PC),
        .halt(halt), .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic stl,
                         input logic rdr, input logic [15:0] rpc, input logic hlt);
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        decode_stall = stl; redirect = rdr; redirect_PC = rpc; halt = hlt;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // scoreboard: every consumed instruction must match the next expected {pc, word}
    always @(negedge clock) begin
        if (reset && instr_valid && !decode_stall) begin
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL consume_extra: got %0h expected none", {instr_pc, instr_out});
            end else begin
                check("consume", {16'h0, instr_pc, instr_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic rdy; logic rv; logic [31:0] rd; logic stl; logic rdr; logic [15:0] rpc; logic hlt;
        logic [2:0] e_st; logic e_req; logic e_sel; logic [15:0] e_tgt; logic e_valid;
        logic [31:0] e_out; logic [15:0] e_ipc; logic [15:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
        input logic stl, input logic rdr, input logic [15:0] rpc, input logic hlt,
        input logic [2:0] e_st, input logic e_req, input logic e_sel, input logic [15:0] e_tgt,
        input logic e_valid, input logic [31:0] e_out, input logic [15:0] e_ipc,
        input logic [15:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
        v.e_st = e_st; v.e_req = e_req; v.e_sel = e_sel; v.e_tgt = e_tgt; v.e_valid = e_valid;
        v.e_out = e_out; v.e_ipc = e_ipc; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        exp_q.push_back({16'h0000, 32'hDEADBEEF});
        exp_q.push_back({16'h0004, 32'h11111111});
        exp_q.push_back({16'hFFFC, 32'h33333333});
        exp_q.push_back({16'h0200, 32'h55555555});
        exp_q.push_back({16'h0300, 32'h66666666});
        exp_q.push_back({16'h0000, 32'h77777777});

        // first fetch
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_IDLE,1'b0,1'b1,16'h0000,1'b0,32'h0,16'h0,16'h0000));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0000,1'b0,32'h0,16'h0,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b0,16'h0000,1'b0,32'h0,16'h0,16'h0000));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_ISSUE,1'b0,1'b1,16'h0004,1'b1,32'hDEADBEEF,16'h0000,16'h0004));
        // ready backpressure, then decode stall
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0004,1'b0,32'hDEADBEEF,16'h0000,16'h0004));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0004,1'b0,32'hDEADBEEF,16'h0000,16'h0004));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b1,16'h0004,1'b0,32'hDEADBEEF,16'h0000,16'h0004));
        vecs.push_back(mk(1'b0,1'b1,32'h11111111,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b0,16'h0004,1'b0,32'hDEADBEEF,16'h0000,16'h0004));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0,1'b0,32'hBAD0BAD0,1'b1,1'b0,16'h0,1'b0, S_ISSUE,1'b0,1'b1,16'h0008,1'b1,32'h11111111,16'h0004,16'h0008));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_ISSUE,1'b0,1'b1,16'h0008,1'b1,32'h11111111,16'h0004,16'h0008));
        // redirect in WAIT, late response drained
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0008,1'b0,32'h11111111,16'h0004,16'h0008));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'h1110,1'b0, S_WAIT,1'b0,1'b1,16'h1110,1'b0,32'h11111111,16'h0004,16'h0008));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_DRAIN,1'b0,1'b1,16'h1110,1'b0,32'h11111111,16'h0004,16'h1110));
        vecs.push_back(mk(1'b0,1'b1,32'hCAFEF00D,1'b0,1'b0,16'h0,1'b0, S_DRAIN,1'b0,1'b1,16'h1110,1'b0,32'h11111111,16'h0004,16'h1110));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h1110,1'b0,32'h11111111,16'h0004,16'h1110));
        // redirect in ISSUE while stalled
        vecs.push_back(mk(1'b0,1'b1,32'h22222222,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b0,16'h1110,1'b0,32'h11111111,16'h0004,16'h1110));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b0,16'h0,1'b0, S_ISSUE,1'b0,1'b1,16'h1114,1'b1,32'h22222222,16'h1110,16'h1114));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b1,16'h1110,1'b0, S_ISSUE,1'b0,1'b1,16'h1110,1'b1,32'h22222222,16'h1110,16'h1114));
        // redirect in REQ to the top of memory, then wrap-around
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'hFFFC,1'b0, S_REQ,1'b1,1'b1,16'hFFFC,1'b0,32'h22222222,16'h1110,16'h1110));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'hFFFC,1'b0,32'h22222222,16'h1110,16'hFFFC));
        vecs.push_back(mk(1'b0,1'b1,32'h33333333,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b0,16'hFFFC,1'b0,32'h22222222,16'h1110,16'hFFFC));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_ISSUE,1'b0,1'b1,16'h0000,1'b1,32'h33333333,16'hFFFC,16'h0000));
        // redirect in WAIT together with the response: data discarded
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0000,1'b0,32'h33333333,16'hFFFC,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,32'h44444444,1'b0,1'b1,16'h0200,1'b0, S_WAIT,1'b0,1'b1,16'h0200,1'b0,32'h33333333,16'hFFFC,16'h0000));
        vecs.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0200,1'b0,32'h33333333,16'hFFFC,16'h0200));
        // redirect and consume in the same ISSUE cycle
        vecs.push_back(mk(1'b0,1'b1,32'h55555555,1'b0,1'b0,16'h0,1'b0, S_WAIT,1'b0,1'b0,16'h0200,1'b0,32'h33333333,16'hFFFC,16'h0200));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b1,16'h0300,1'b0, S_ISSUE,1'b0,1'b1,16'h0300,1'b1,32'h55555555,16'h0200,16'h0204));
        vecs.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,16'h0,1'b0, S_REQ,1'b1,1'b1,16'h0300,1'b0,32'h55555555,16'h0200,16'h0300));

        // reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));
        check("rst_req", 64'(imem_req), 64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_out", 64'(instr_out), 64'h0);
        check("rst_ipc", 64'(instr_pc), 64'h0);
        check("rst_sel", 64'(next_PC_select), 64'h1);
        check("rst_tgt", 64'(target_PC), 64'(pc));
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rdy, vecs[k].rv, vecs[k].rd, vecs[k].stl, vecs[k].rdr, vecs[k].rpc, vecs[k].hlt);
            #1;
            check($sformatf("v%0d_state", k), 64'(fsm_state), 64'(vecs[k].e_st));
            check($sformatf("v%0d_req", k), 64'(imem_req), 64'(vecs[k].e_req));
            check($sformatf("v%0d_addr", k), 64'(imem_addr), 64'(vecs[k].e_pc));
            check($sformatf("v%0d_pc", k), 64'(pc), 64'(vecs[k].e_pc));
            check($sformatf("v%0d_sel", k), 64'(next_PC_select), 64'(vecs[k].e_sel));
            if (vecs[k].e_sel)
                check($sformatf("v%0d_tgt", k), 64'(target_PC), 64'(vecs[k].e_tgt));
            check($sformatf("v%0d_valid", k), 64'(instr_valid), 64'(vecs[k].e_valid));
            check($sformatf("v%0d_out", k), 64'(instr_out), 64'(vecs[k].e_out));
            check($sformatf("v%0d_ipc", k), 64'(instr_pc), 64'(vecs[k].e_ipc));
            tick();
        end

        // halt on consume, then HALTED held for 20 cycles despite memory and redirect activity
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("h_req", 64'(imem_req), 64'h1);
        tick();
        drive(1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("h_wait", 64'(fsm_state), 64'(S_WAIT));
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        #1 check("h_issue_valid", 64'(instr_valid), 64'h1);
        check("h_issue_pc", 64'(pc), 64'h0304);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'h0, 1'b0, 1'(i % 2), 16'h0400, 1'b0);
            #1;
            check($sformatf("halted%0d_state", i), 64'(fsm_state), 64'(S_HALTED));
            check($sformatf("halted%0d_req", i), 64'(imem_req), 64'h0);
            check($sformatf("halted%0d_valid", i), 64'(instr_valid), 64'h0);
            check($sformatf("halted%0d_pc", i), 64'(pc), 64'h0304);
            tick();
        end

        // reset pulse restarts at 0x0000; then halt together with redirect in ISSUE
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        reset = 1'b0;
        #1 check("rr_state", 64'(fsm_state), 64'(S_IDLE));
        check("rr_pc", 64'(pc), 64'h0);
        check("rr_out", 64'(instr_out), 64'h0);
        tick();
        reset = 1'b1;
        #1 check("rr_idle", 64'(fsm_state), 64'(S_IDLE));
        check("rr_idle_req", 64'(imem_req), 64'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("rr_req", 64'(imem_req), 64'h1);
        check("rr_addr", 64'(imem_addr), 64'h0000);
        tick();
        drive(1'b0, 1'b1, 32'h77777777, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("rr_wait", 64'(fsm_state), 64'(S_WAIT));
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'h0800, 1'b1);
        #1 check("hr_out", 64'(instr_out), 64'h77777777);
        check("hr_sel", 64'(next_PC_select), 64'h1);
        check("hr_tgt", 64'(target_PC), 64'h0800);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("hr_state", 64'(fsm_state), 64'(S_HALTED));
        check("hr_pc", 64'(pc), 64'h0800);
        check("hr_valid", 64'(instr_valid), 64'h0);

        // halt seen in IDLE goes straight to HALTED
        reset = 1'b0;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        reset = 1'b1;
        #1 check("ih_idle", 64'(fsm_state), 64'(S_IDLE));
        tick();
        check("ih_state", 64'(fsm_state), 64'(S_HALTED));
        check("ih_req", 64'(imem_req), 64'h0);
        tick();
        check("ih_state2", 64'(fsm_state), 64'(S_HALTED));
        check("ih_pc", 64'(pc), 64'h0000);

        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
